// File: rtl/fifo_sample_pacer_if.sv
// Drain-side FIFO port bundle: show-ahead data, empty flag and the pop strobe.
interface fifo_sample_pacer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;

  // master: the pacer popping the FIFO; slave: the FIFO itself
  modport master (input in_dout, input in_empty, output in_rd_en);
  modport slave  (output in_dout, output in_empty, input in_rd_en);
endinterface

// File: rtl/fifo_sample_pacer.sv
// Paced FIFO drain: one pop every SAMPLE_DIV clocks, fixed-point to saturated
// 16-bit PCM, presented as a parallel word and as an MSB-first serial frame.
module fifo_sample_pacer #(
  parameter int unsigned SAMPLE_DIV = 20,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  fifo_sample_pacer_if.master        fifo,
  output logic [15:0]                sample_out,
  output logic                       sample_valid,
  output logic                       ser_data,
  output logic                       ser_frame,
  output logic [15:0]                underrun_count
);
  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [DATA_WIDTH-1:0] PCM_MAX = DATA_WIDTH'(32767);
  localparam logic signed [DATA_WIDTH-1:0] PCM_MIN = DATA_WIDTH'(-32768);

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

  logic [CNT_W-1:0]             div_cnt;
  logic                         tick;
  logic signed [DATA_WIDTH-1:0] scaled;
  logic [15:0]                  pcm;
  logic [15:0]                  sample_q;
  logic [15:0]                  underrun_q;
  logic                         valid_q;
  logic [15:0]                  load_word;

  ser_state_t                   state, state_nx;
  logic [15:0]                  shreg, shreg_nx;
  logic [3:0]                   bit_idx, bit_idx_nx;

  // Tick is masked by reset so a reset landing on the tick cycle never pops.
  assign tick          = (div_cnt == CNT_LAST) && !reset;
  assign fifo.in_rd_en = tick && !fifo.in_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign scaled = $signed(fifo.in_dout) >>> FRAC_BITS;

  always_comb begin
    pcm = scaled[15:0];
    if (scaled > PCM_MAX) begin
      pcm = 16'h7FFF;
    end else if (scaled < PCM_MIN) begin
      pcm = 16'h8000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= '0;
    end else begin
      valid_q <= tick;
      if (fifo.in_rd_en) begin
        sample_q <= pcm;
      end else if (tick && (underrun_q != '1)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  // Frame carries the value sample_out takes at the same edge (new or held).
  assign load_word = fifo.in_rd_en ? pcm : sample_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_idx <= bit_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    ser_data   = 1'b0;
    ser_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nx   = SHIFT;
          shreg_nx   = load_word;
          bit_idx_nx = 4'd15;
        end
      end
      SHIFT: begin
        ser_data   = shreg[15];
        ser_frame  = (bit_idx == 4'd15);
        shreg_nx   = {shreg[14:0], 1'b0};
        bit_idx_nx = bit_idx - 4'd1;
        if (bit_idx == 4'd0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sample_out     = sample_q;
  assign sample_valid   = valid_q;
  assign underrun_count = underrun_q;
endmodule

// File: tb/tb_fifo_sample_pacer.sv
// Bench for fifo_sample_pacer: cycle-level reference model built from cycle
// counts and arithmetic, plus a conversion table and directed corner sequences.
module tb_fifo_sample_pacer;
  localparam int unsigned DIV  = 20;
  localparam int unsigned FRAC = 10;
  localparam int unsigned DW   = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        ser_data;
  logic        ser_frame;
  logic [15:0] underrun_count;

  fifo_sample_pacer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_sample_pacer #(
    .SAMPLE_DIV(DIV),
    .FRAC_BITS (FRAC),
    .DATA_WIDTH(DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fifo          (bus),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .ser_data      (ser_data),
    .ser_frame     (ser_frame),
    .underrun_count(underrun_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] din;
    int          exp;
  } vec_t;
  vec_t tv[12];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] fq[$];
  bit starve = 1'b0;
  bit rst_req = 1'b1;
  bit pend_pop = 1'b0;

  // reference model state: cycles since reset release and expected outputs
  int          cyc = 0;
  int          m_sample = 0;
  int          m_under = 0;
  bit          m_valid = 1'b0;
  int          m_pos = -1;
  logic [15:0] m_word = '0;
  int          pop_cyc[$];
  int          last_valid_cyc = -1;
  bit          saw_valid = 1'b0;
  logic [15:0] ser_acc = '0;
  int          ser_n = 16;

  function automatic int pcm_of(logic [31:0] w);
    longint x, d, q;
    x = longint'($signed(w));
    d = longint'(1) << FRAC;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic cycle();
    bit tk, pop, exp_d;
    @(negedge clock);
    if (pend_pop && fq.size() > 0) void'(fq.pop_front());
    pend_pop = 1'b0;
    reset = rst_req;
    bus.in_empty = starve || (fq.size() == 0);
    bus.in_dout = (fq.size() > 0) ? fq[0] : $urandom();
    #1;
    tk  = !reset && (cyc % DIV == DIV - 1);
    pop = tk && !bus.in_empty;
    exp_d = (m_pos >= 0) ? m_word[15 - m_pos] : 1'b0;
    chk("in_rd_en", int'(bus.in_rd_en), int'(pop));
    chk("sample_out", int'($signed(sample_out)), m_sample);
    chk("sample_valid", int'(sample_valid), int'(m_valid));
    chk("underrun_count", int'(underrun_count), m_under);
    chk("ser_data", int'(ser_data), int'(exp_d));
    chk("ser_frame", int'(ser_frame), int'(m_pos == 0));
    saw_valid = sample_valid;
    if (sample_valid) last_valid_cyc = cyc;
    if (ser_frame) ser_n = 0;
    if (ser_n < 16) begin
      ser_acc = {ser_acc[14:0], ser_data};
      ser_n++;
    end
    pend_pop = bus.in_rd_en;
    if (bus.in_rd_en) pop_cyc.push_back(cyc);
    if (reset) begin
      cyc = 0; m_valid = 1'b0; m_sample = 0; m_under = 0; m_pos = -1;
      pop_cyc.delete();
    end else begin
      if (pop) m_sample = pcm_of(bus.in_dout);
      else if (tk && m_under < 65535) m_under++;
      m_valid = tk;
      if (tk) begin
        m_word = 16'(m_sample);
        m_pos = 0;
      end else if (m_pos == 15) m_pos = -1;
      else if (m_pos >= 0) m_pos++;
      cyc++;
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      cycle();
      if (saw_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
  endtask

  initial begin
    int bad;
    logic [31:0] w;
    tv[0]  = '{32'h0000_0400, 1};
    tv[1]  = '{32'h01FF_FC00, 32767};
    tv[2]  = '{32'hFE00_0000, -32768};
    tv[3]  = '{32'hFFFF_FC00, -1};
    tv[4]  = '{32'hFFFF_FFFF, -1};
    tv[5]  = '{32'h0000_0001, 0};
    tv[6]  = '{32'h0020_0000, 2048};
    tv[7]  = '{32'h0200_0000, 32767};
    tv[8]  = '{32'hFDFF_FC00, -32768};
    tv[9]  = '{32'h7FFF_FFFF, 32767};
    tv[10] = '{32'h8000_0000, -32768};
    tv[11] = '{32'hFFFF_8000, -32};

    reset = 1'b1;
    bus.in_empty = 1'b1;
    bus.in_dout = '0;
    repeat (3) @(posedge clock);

    // first sample after reset: pop at cycle 19, valid at 20, frame 0x0001
    fq.push_back(32'h0000_0400);
    do_reset();
    repeat (DIV + 17) cycle();
    chk("first_pop_count", pop_cyc.size(), 1);
    chk("first_pop_cycle", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, DIV - 1);
    chk("first_valid_cycle", last_valid_cyc, DIV);
    chk("first_ser_word", int'(ser_acc), 1);

    // conversion table: shift, floor, saturation, sign
    foreach (tv[i]) begin
      fq.push_back(tv[i].din);
      wait_valid();
      chk("tbl_sample", int'($signed(sample_out)), tv[i].exp);
    end

    // underrun: hold last sample, still pulse, count 3, no pops
    do_reset();
    fq.push_back(32'h0000_1400);
    wait_valid();
    chk("ur_first", int'($signed(sample_out)), 5);
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      chk("ur_hold", int'($signed(sample_out)), 5);
      chk("ur_spacing", last_valid_cyc, DIV * (k + 2));
    end
    chk("ur_count", int'(underrun_count), 3);
    chk("ur_pops", pop_cyc.size(), 1);

    // saturation of the underrun counter
    force dut.underrun_q = 16'hFFFE;
    #1;
    release dut.underrun_q;
    m_under = 65534;
    repeat (3) wait_valid();
    chk("ur_saturate", int'(underrun_count), 65535);
    cycle();
    chk("ur_hold_max", int'(underrun_count), 65535);

    // reset in the bit-7 cycle of a frame
    fq.push_back(32'h0015_5400);
    wait_valid();
    repeat (7) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    chk("mid_rst_ser_data", int'(ser_data), 0);
    chk("mid_rst_ser_frame", int'(ser_frame), 0);
    chk("mid_rst_underrun", int'(underrun_count), 0);
    chk("mid_rst_sample", int'(sample_out), 0);
    fq.delete();
    fq.push_back(32'hFFFF_F000);
    wait_valid();
    chk("post_rst_valid_cycle", last_valid_cyc, DIV);
    repeat (17) cycle();
    chk("post_rst_ser_word", int'(ser_acc), 16'hFFFC);

    // reset asserted on a tick cycle with data waiting: no pop
    do_reset();
    fq.push_back(32'h0000_0800);
    for (int i = 0; i < 2 * DIV && cyc != DIV - 1; i++) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    chk("tick_rst_no_pop", pop_cyc.size(), 0);
    chk("tick_rst_fifo_level", fq.size(), 1);

    // 100 ticks of continuous data
    fq.delete();
    fq.push_back($urandom());
    do_reset();
    for (int i = 0; i < 100 * DIV; i++) begin
      if (fq.size() < 2) fq.push_back($urandom());
      cycle();
    end
    chk("cont_pop_count", pop_cyc.size(), 100);
    bad = 0;
    for (int i = 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] != DIV) bad++;
    chk("cont_pop_spacing", bad, 0);
    chk("cont_first_pop", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, DIV - 1);

    // randomized traffic with random underruns
    fq.delete();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0 && fq.size() == 0) begin
        w = $urandom();
        if ($urandom_range(0, 1) == 1) w = 32'($signed(w) >>> 6);
        fq.push_back(w);
      end
      repeat (DIV) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_sample_pacer.md
Name: fifo_sample_pacer

Overview:
- Drain-side reader for the 32-bit sample FIFOs at the end of the processing chain.
- Pops one fixed-point sample every SAMPLE_DIV clocks, rescales and saturates it to 16-bit signed PCM, and presents it as a parallel word and as an MSB-first serial frame for the audio DAC interface.
- Counts FIFO underruns; on underrun it repeats the last sample.

Parameters:
- SAMPLE_DIV, 20: clocks per output sample; legal range 18..65535.
- FRAC_BITS, 10: fractional bits of the incoming fixed-point sample; legal range 0..16.
- DATA_WIDTH, 32: width of FIFO samples.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_dout  in  DATA_WIDTH  FIFO show-ahead data; valid whenever in_empty=0.
- in_empty  in  1  FIFO empty flag.
- in_rd_en  out  1  FIFO pop; one pop per cycle asserted.
- sample_out  out  16  current PCM sample, signed.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- ser_data  out  1  serial PCM bit, MSB first.
- ser_frame  out  1  high during the MSB bit cycle of each frame.
- underrun_count  out  16  saturating count of missed samples.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset values: all outputs 0; divider 0; serializer IDLE; held sample 0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick=1 when the count is SAMPLE_DIV-1.
  - First tick occurs in the (SAMPLE_DIV)th cycle after reset deasserts.
- in_rd_en:
  - Combinational: tick & ~in_empty.
  - Never asserted outside tick and never asserted while in reset.
  - Exactly one pop per tick at most.
- Capture on tick with in_empty=0:
  - in_dout is treated as signed.
  - Arithmetic shift right by FRAC_BITS (truncates toward -inf).
  - Clamp to [-32768, 32767].
  - Register into sample_out at the same edge; sample_valid=1 in the following cycle.
- Underrun (tick with in_empty=1):
  - sample_out holds its previous value.
  - sample_valid still pulses.
  - underrun_count increments, saturating at 16'hFFFF (no wrap).
- in_empty deasserting in a non-tick cycle has no effect until the next tick.
- Latency: tick edge -> sample_out/sample_valid 1 cycle; ser_frame/first ser_data bit in the same cycle as sample_valid.
- Serializer FSM:
  - IDLE: ser_data=0, ser_frame=0. On the tick edge, load a 16-bit shift register with the new/held sample, set bit index to 15, and enter SHIFT.
  - SHIFT: ser_data = shift register bit 15; ser_frame=1 only when index=15; shift left each cycle. After the index-0 bit cycle, return to IDLE.
  - One frame is 16 cycles. SAMPLE_DIV>=18 guarantees IDLE before the next tick; no overlap handling required.
- Reset asserted mid-frame: serializer to IDLE, ser_data=0 on the next edge, the partial frame is discarded, and underrun_count clears.
- Reset asserted on a tick cycle: no pop (in_rd_en=0).

Test Plan:
- Reset, then FIFO preloaded with 0x00000400, SAMPLE_DIV=20, FRAC_BITS=10 -> in_rd_en pulses once at cycle 19 after reset; sample_out=1 with sample_valid at cycle 20; ser_data = 0x0001 MSB first with ser_frame on the first bit.
- Samples 0x01FFFC00, 0xFE000000, 0xFFFFFC00 -> sample_out = 32767, -32768, -1 (saturation and sign).
- FIFO empty for 3 ticks after sample 5 -> sample_out stays 5, sample_valid still pulses every 20 cycles, underrun_count=3, in_rd_en never asserted.
- underrun_count forced to 65534, then 3 underruns -> reads 65535 and holds.
- Reset asserted at bit 7 of a frame -> ser_data/ser_frame=0 next cycle, all outputs 0, next frame starts cleanly 20 cycles after release.
- Continuous non-empty FIFO for 100 ticks -> exactly 100 pops spaced exactly 20 cycles apart, no double pop.
